// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, colour and position types shared by the video path
package vga_timing_pkg;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  typedef logic [5:0] color_t;
  typedef logic [9:0] hpos_t;
  typedef logic [9:0] vpos_t;
endpackage

// File: rtl/vga_sync_generator_wrap_counter.sv
// wrap_counter: counter reset to MAX that wraps MAX->0 when en; ports clk, reset, en -> count, wrap (en && count==MAX)
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX = 799
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  assign wrap = en && count == WIDTH'(MAX);
  always_ff @(posedge clk)
    count <= reset ? WIDTH'(MAX) : wrap ? '0 : en ? count + WIDTH'(1) : count;
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: registered VGA timing; clk, reset -> hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count (FRAME_COUNTER_EN)
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
`ifdef FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_count
`endif
);
  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS0 = H_DISPLAY + H_FRONT;
  localparam int HS1 = HS0 + H_SYNC - 1;
  localparam int VS0 = V_DISPLAY + V_FRONT;
  localparam int VS1 = VS0 + V_SYNC - 1;
  if (HT > 1024 || VT > 1024) begin : g_bad_timing
    $error("vga_sync_generator: H_TOTAL or V_TOTAL exceeds 1024");
  end
  logic       h_wrap, v_wrap;
  hpos_t      h_next;
  vpos_t      v_next;
  wrap_counter #(.WIDTH(10), .MAX(HT - 1)) u_h (
    .clk(clk), .reset(reset), .en(1'b1), .count(hpos), .wrap(h_wrap)
  );
  wrap_counter #(.WIDTH(10), .MAX(VT - 1)) u_v (
    .clk(clk), .reset(reset), .en(h_wrap), .count(vpos), .wrap(v_wrap)
  );
  // decoding the values the counters take on this edge keeps outputs aligned with hpos/vpos
  always_comb begin
    h_next = h_wrap ? '0 : hpos + 10'd1;
    v_next = v_wrap ? '0 : vpos + 10'(h_wrap);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= ~H_SYNC_POL;
      vsync <= ~V_SYNC_POL;
      display_on <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync <= (h_next >= 10'(HS0) && h_next <= 10'(HS1)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync <= (v_next >= 10'(VS0) && v_next <= 10'(VS1)) ? V_SYNC_POL : ~V_SYNC_POL;
      display_on <= h_next < 10'(H_DISPLAY) && v_next < 10'(V_DISPLAY);
      line_start <= h_wrap;
      frame_start <= v_wrap;
    end
  end
`ifdef FRAME_COUNTER_EN
  always_ff @(posedge clk)
    frame_count <= reset ? 8'd0 : frame_count + 8'(v_wrap);
`endif
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed checks of default timing and a small reversed-polarity timing instance
module tb_vga_sync_generator;
  logic clk = 1'b0;
  logic rst_d = 1'b1, rst_s = 1'b1;
  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
  logic d_hsync, d_vsync, d_de, d_ls, d_fs;
  logic s_hsync, s_vsync, s_de, s_ls, s_fs;
`ifdef FRAME_COUNTER_EN
  logic [7:0] d_fc, s_fc;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vga_sync_generator u_d (
    .clk(clk), .reset(rst_d), .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
    .display_on(d_de), .line_start(d_ls), .frame_start(d_fs)
`ifdef FRAME_COUNTER_EN
    , .frame_count(d_fc)
`endif
  );

  // small frame: H 8+2+3+2=15 (hsync 10..12), V 6+1+2+2=11 (vsync 7..8), 165 cycles per frame
  vga_sync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_s (
    .clk(clk), .reset(rst_s), .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
    .display_on(s_de), .line_start(s_ls), .frame_start(s_fs)
`ifdef FRAME_COUNTER_EN
    , .frame_count(s_fc)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (d_hpos !== 10'd799) begin errors++; $display("FAIL reset_hpos got %0d want 799", d_hpos); end
    checks++; if (d_vpos !== 10'd524) begin errors++; $display("FAIL reset_vpos got %0d want 524", d_vpos); end
    checks++; if ({d_de, d_ls, d_fs} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {d_de, d_ls, d_fs}); end
    checks++; if ({d_hsync, d_vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b want 11", {d_hsync, d_vsync}); end
`ifdef FRAME_COUNTER_EN
    checks++; if (d_fc !== 8'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", d_fc); end
`endif
    rst_d = 1'b0;
    tick(1);
    checks++; if ({d_hpos, d_vpos} !== 20'd0) begin errors++; $display("FAIL release_pos got %0d,%0d want 0,0", d_hpos, d_vpos); end
    checks++; if ({d_de, d_ls, d_fs, d_hsync, d_vsync} !== 5'b11111) begin errors++; $display("FAIL release_flags got %b want 11111", {d_de, d_ls, d_fs, d_hsync, d_vsync}); end
  endtask

  task automatic test_line;
    int bad_h = 0, bad_ls = 0, n_low = 0, first_low = -1, last_low = -1, de_off = -1;
    for (int i = 1; i < 800; i++) begin
      tick(1);
      if (d_hpos !== 10'(i) || d_vpos !== 10'd0) bad_h++;
      if (d_ls !== 1'b0 || d_fs !== 1'b0) bad_ls++;
      if (d_hsync === 1'b0) begin
        n_low++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      if (d_de === 1'b0 && de_off < 0) de_off = i;
    end
    checks++; if (bad_h != 0) begin errors++; $display("FAIL line_hpos_seq got %0d bad cycles want 0", bad_h); end
    checks++; if (bad_ls != 0) begin errors++; $display("FAIL line_pulses got %0d stray cycles want 0", bad_ls); end
    checks++; if (n_low != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", n_low); end
    checks++; if (first_low != 656 || last_low != 751) begin errors++; $display("FAIL hsync_window got %0d..%0d want 656..751", first_low, last_low); end
    checks++; if (de_off != 640) begin errors++; $display("FAIL de_fall got %0d want 640", de_off); end
    tick(1);
    checks++; if ({d_hpos, d_vpos} !== {10'd0, 10'd1}) begin errors++; $display("FAIL line_wrap got %0d,%0d want 0,1", d_hpos, d_vpos); end
    checks++; if ({d_ls, d_fs} !== 2'b10) begin errors++; $display("FAIL line_wrap_pulses got %b want 10", {d_ls, d_fs}); end
  endtask

  task automatic test_mid_reset_default;
    int n = 0;
    while (d_hpos !== 10'd700 && n < 1000) begin tick(1); n++; end
    checks++; if (d_hpos !== 10'd700) begin errors++; $display("FAIL wait_h700 got %0d want 700", d_hpos); end
    checks++; if (d_hsync !== 1'b0) begin errors++; $display("FAIL hsync_at700 got %b want 0", d_hsync); end
    rst_d = 1'b1;
    tick(1);
    checks++; if ({d_hpos, d_vpos} !== {10'd799, 10'd524}) begin errors++; $display("FAIL midreset_pos got %0d,%0d want 799,524", d_hpos, d_vpos); end
    checks++; if ({d_hsync, d_vsync, d_de} !== 3'b110) begin errors++; $display("FAIL midreset_out got %b want 110", {d_hsync, d_vsync, d_de}); end
    rst_d = 1'b0;
    tick(1);
    checks++; if ({d_hpos, d_vpos, d_fs} !== {20'd0, 1'b1}) begin errors++; $display("FAIL midreset_restart got %0d,%0d,%b want 0,0,1", d_hpos, d_vpos, d_fs); end
  endtask

  task automatic test_frame_small;
    int n_vs, n_hs, n_de, de_low_band = 0, fs_early = 0, v_lo = -1, v_hi = -1, bad_edge = 0;
    logic prev_vs;
    checks++; if ({s_hsync, s_vsync, s_de} !== 3'b000) begin errors++; $display("FAIL pol_reset got %b want 000", {s_hsync, s_vsync, s_de}); end
    rst_s = 1'b0;
    tick(1);
    checks++; if ({s_hpos, s_vpos, s_fs, s_ls, s_de} !== {20'd0, 3'b111}) begin errors++; $display("FAIL small_release got %0d,%0d,%b%b%b want 0,0,111", s_hpos, s_vpos, s_fs, s_ls, s_de); end
    n_vs = int'(s_vsync);
    n_hs = int'(s_hsync);
    n_de = int'(s_de);
    prev_vs = s_vsync;
    for (int i = 1; i < 165; i++) begin
      tick(1);
      if (s_vsync === 1'b1) begin
        n_vs++;
        if (v_lo < 0) v_lo = int'(s_vpos);
        v_hi = int'(s_vpos);
      end
      if (s_vsync !== prev_vs && s_hpos !== 10'd0) bad_edge++;
      prev_vs = s_vsync;
      if (s_hsync === 1'b1) n_hs++;
      if (s_de === 1'b1) n_de++;
      if (s_de !== 1'b0 && s_vpos >= 10'd6) de_low_band++;
      if (s_fs !== 1'b0) fs_early++;
    end
    checks++; if (n_vs != 30) begin errors++; $display("FAIL vsync_width got %0d want 30", n_vs); end
    checks++; if (v_lo != 7 || v_hi != 8) begin errors++; $display("FAIL vsync_lines got %0d..%0d want 7..8", v_lo, v_hi); end
    checks++; if (bad_edge != 0) begin errors++; $display("FAIL vsync_edge got %0d off-boundary changes want 0", bad_edge); end
    checks++; if (n_hs != 33) begin errors++; $display("FAIL hsync_pol_count got %0d want 33", n_hs); end
    checks++; if (n_de != 48) begin errors++; $display("FAIL de_count got %0d want 48", n_de); end
    checks++; if (de_low_band != 0) begin errors++; $display("FAIL de_blank_lines got %0d want 0", de_low_band); end
    checks++; if (fs_early != 0) begin errors++; $display("FAIL fs_early got %0d want 0", fs_early); end
    tick(1);
    checks++; if ({s_hpos, s_vpos, s_fs} !== {20'd0, 1'b1}) begin errors++; $display("FAIL frame_period got %0d,%0d,%b want 0,0,1", s_hpos, s_vpos, s_fs); end
  endtask

  task automatic test_mid_reset_small;
    int n = 0;
    while (!(s_hpos === 10'd11 && s_vpos === 10'd7) && n < 400) begin tick(1); n++; end
    checks++; if ({s_hpos, s_vpos} !== {10'd11, 10'd7}) begin errors++; $display("FAIL wait_11_7 got %0d,%0d want 11,7", s_hpos, s_vpos); end
    checks++; if ({s_hsync, s_vsync} !== 2'b11) begin errors++; $display("FAIL in_sync got %b want 11", {s_hsync, s_vsync}); end
    rst_s = 1'b1;
    tick(1);
    checks++; if ({s_hpos, s_vpos} !== {10'd14, 10'd10}) begin errors++; $display("FAIL small_midreset_pos got %0d,%0d want 14,10", s_hpos, s_vpos); end
    checks++; if ({s_hsync, s_vsync, s_de, s_ls, s_fs} !== 5'b00000) begin errors++; $display("FAIL small_midreset_out got %b want 00000", {s_hsync, s_vsync, s_de, s_ls, s_fs}); end
    rst_s = 1'b0;
    tick(1);
    checks++; if ({s_hpos, s_vpos, s_fs} !== {20'd0, 1'b1}) begin errors++; $display("FAIL small_restart got %0d,%0d,%b want 0,0,1", s_hpos, s_vpos, s_fs); end
  endtask

`ifdef FRAME_COUNTER_EN
  task automatic test_frame_counter;
    int bad = 0;
    logic [7:0] exp_fc;
    checks++; if (s_fc !== 8'd1) begin errors++; $display("FAIL fc_first got %0d want 1", s_fc); end
    for (int k = 2; k <= 256; k++) begin
      tick(165);
      exp_fc = 8'(k);
      if (s_fs !== 1'b1 || s_fc !== exp_fc) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fc_sequence got %0d bad frames want 0", bad); end
    checks++; if (s_fc !== 8'd0) begin errors++; $display("FAIL fc_wrap got %0d want 0", s_fc); end
    rst_s = 1'b1;
    tick(1);
    checks++; if (s_fc !== 8'd0) begin errors++; $display("FAIL fc_reset got %0d want 0", s_fc); end
    rst_s = 1'b0;
    tick(1);
    checks++; if (s_fc !== 8'd1) begin errors++; $display("FAIL fc_after_reset got %0d want 1", s_fc); end
  endtask
`endif

  initial begin
    test_reset;
    test_line;
    test_mid_reset_default;
    test_frame_small;
    test_mid_reset_small;
`ifdef FRAME_COUNTER_EN
    test_frame_counter;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
